// File: rtl/ruby_l1d_responder_if.sv
// ruby_l1d_responder_if: LSU<->L1D request/response channel.
// master = LSU side, slave = L1D responder side.
interface ruby_l1d_responder_if #(
  parameter int LSU_ID_W   = 4,
  parameter int ROB_TAG_W  = 6,
  parameter int PREG_TAG_W = 7,
  parameter int PADDR_W    = 56
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [LSU_ID_W-1:0]   req_lsu_id;
  logic [ROB_TAG_W-1:0]  req_rob_id;
  logic [5:0]            req_type;
  logic [PADDR_W-1:0]    req_paddr;
  logic [PREG_TAG_W-1:0] req_ld_rd_idx;
  logic [63:0]           req_st_dat;
  logic                  req_is_cacheable;
  logic                  req_is_secure;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [LSU_ID_W-1:0]   resp_lsu_id;
  logic [ROB_TAG_W-1:0]  resp_rob_id;
  logic [5:0]            resp_req_type;
  logic [63:0]           resp_ld_data;
  logic [PREG_TAG_W-1:0] resp_ld_rd_idx;
  logic                  resp_err;

  modport master (
    output req_valid, req_lsu_id, req_rob_id, req_type,
    output req_paddr, req_ld_rd_idx, req_st_dat,
    output req_is_cacheable, req_is_secure, resp_ready,
    input  req_ready, resp_valid, resp_lsu_id, resp_rob_id,
    input  resp_req_type, resp_ld_data, resp_ld_rd_idx, resp_err
  );

  modport slave (
    input  req_valid, req_lsu_id, req_rob_id, req_type,
    input  req_paddr, req_ld_rd_idx, req_st_dat,
    input  req_is_cacheable, req_is_secure, resp_ready,
    output req_ready, resp_valid, resp_lsu_id, resp_rob_id,
    output resp_req_type, resp_ld_data, resp_ld_rd_idx, resp_err
  );
endinterface

// File: rtl/ruby_l1d_responder.sv
// ruby_l1d_responder: fixed-latency behavioural L1D that answers
// LSU requests in order from a small internal data array.
module ruby_l1d_responder #(
  parameter int LSU_ID_W   = 4,
  parameter int ROB_TAG_W  = 6,
  parameter int PREG_TAG_W = 7,
  parameter int PADDR_W    = 56,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ruby_l1d_responder_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [5:0] LB  = 6'd1;
  localparam logic [5:0] LBU = 6'd2;
  localparam logic [5:0] LH  = 6'd3;
  localparam logic [5:0] LHU = 6'd4;
  localparam logic [5:0] LW  = 6'd5;
  localparam logic [5:0] LWU = 6'd6;
  localparam logic [5:0] LD  = 6'd7;
  localparam logic [5:0] SB  = 6'd8;
  localparam logic [5:0] SH  = 6'd9;
  localparam logic [5:0] SW  = 6'd10;
  localparam logic [5:0] SD  = 6'd11;

  typedef struct packed {
    logic [LSU_ID_W-1:0]   lsu_id;
    logic [ROB_TAG_W-1:0]  rob_id;
    logic [5:0]            req_type;
    logic [63:0]           ld_data;
    logic [PREG_TAG_W-1:0] rd_idx;
    logic                  err;
  } pay_t;

  logic          acc, deq;
  logic          is_b, is_h, is_w, is_d;
  logic          known, is_st, is_sx;
  logic          misal, oob, err;
  logic [2:0]    off, amask;
  logic [7:0]    bmask, be;
  logic [IW-1:0] widx;
  logic [63:0]   word, sh, wdata, ld_val;
  pay_t          acc_p;
  logic [63:0]   mem [DEPTH];
  logic          unused;

  assign unused = bus.req_is_secure;

  assign acc   = bus.req_valid && bus.req_ready;
  assign off   = bus.req_paddr[2:0];
  assign widx  = bus.req_paddr[3 +: IW];
  assign word  = mem[widx];
  assign sh    = word >> {off, 3'b000};
  assign wdata = bus.req_st_dat << {off, 3'b000};
  assign be    = bmask << off;

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    is_d = 1'b0;
    unique case (bus.req_type)
      LB, LBU, SB: is_b = 1'b1;
      LH, LHU, SH: is_h = 1'b1;
      LW, LWU, SW: is_w = 1'b1;
      LD, SD:      is_d = 1'b1;
      default: ;
    endcase
  end

  assign known = is_b | is_h | is_w | is_d;
  assign is_st = known && (bus.req_type >= SB);
  assign is_sx = (bus.req_type == LB) ||
                 (bus.req_type == LH) ||
                 (bus.req_type == LW);

  always_comb begin
    amask  = 3'b000;
    bmask  = 8'h00;
    ld_val = '0;
    unique case (1'b1)
      is_b: begin
        bmask  = 8'h01;
        ld_val = {{56{is_sx & sh[7]}}, sh[7:0]};
      end
      is_h: begin
        amask  = 3'b001;
        bmask  = 8'h03;
        ld_val = {{48{is_sx & sh[15]}}, sh[15:0]};
      end
      is_w: begin
        amask  = 3'b011;
        bmask  = 8'h0F;
        ld_val = {{32{is_sx & sh[31]}}, sh[31:0]};
      end
      is_d: begin
        amask  = 3'b111;
        bmask  = 8'hFF;
        ld_val = sh;
      end
      default: ;
    endcase
  end

  // Anything at or above DEPTH*8 has a bit set above the index field.
  assign oob   = |bus.req_paddr[PADDR_W-1:IW+3];
  assign misal = |(off & amask);
  assign err   = !known || misal || oob || !bus.req_is_cacheable;

  always_comb begin
    acc_p.lsu_id   = bus.req_lsu_id;
    acc_p.rob_id   = bus.req_rob_id;
    acc_p.req_type = bus.req_type;
    acc_p.ld_data  = (err || is_st) ? '0 : ld_val;
    acc_p.rd_idx   = bus.req_ld_rd_idx;
    acc_p.err      = err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (acc && is_st && !err) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  logic push_v;
  pay_t push_p;

  // The FIFO write is the last of the LATENCY stages.
  if (LATENCY == 1) begin : g_direct
    assign push_v = acc;
    assign push_p = acc_p;
  end else begin : g_pipe
    localparam int NS = LATENCY - 1;
    logic [NS-1:0] pv;
    pay_t          pp [NS];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pv <= '0;
        for (int i = 0; i < NS; i++) pp[i] <= '0;
      end else begin
        pv[0] <= acc;
        pp[0] <= acc_p;
        for (int i = 1; i < NS; i++) begin
          pv[i] <= pv[i-1];
          pp[i] <= pp[i-1];
        end
      end
    end
    assign push_v = pv[NS-1];
    assign push_p = pp[NS-1];
  end

  logic [FW:0] wp, rp, inflight;
  pay_t        fifo [FIFO_DEPTH];
  pay_t        head;

  assign bus.resp_valid = (wp != rp);
  assign deq            = bus.resp_valid && bus.resp_ready;
  assign bus.req_ready  = ~inflight[FW];
  assign head = bus.resp_valid ? fifo[rp[FW-1:0]] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      inflight <= '0;
    end else begin
      if (push_v) wp <= wp + (FW+1)'(1);
      if (deq)    rp <= rp + (FW+1)'(1);
      case ({acc, deq})
        2'b10:   inflight <= inflight + (FW+1)'(1);
        2'b01:   inflight <= inflight - (FW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_v) fifo[wp[FW-1:0]] <= push_p;
  end

  assign bus.resp_lsu_id    = head.lsu_id;
  assign bus.resp_rob_id    = head.rob_id;
  assign bus.resp_req_type  = head.req_type;
  assign bus.resp_ld_data   = head.ld_data;
  assign bus.resp_ld_rd_idx = head.rd_idx;
  assign bus.resp_err       = head.err;
endmodule

// File: tb/tb_ruby_l1d_responder.sv
// tb_ruby_l1d_responder: vector table, directed corner sequences
// and random traffic scored against a byte-array reference model.
module tb_ruby_l1d_responder;
  localparam int DEPTH      = 64;
  localparam int LATENCY    = 3;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ruby_l1d_responder_if bus ();

  ruby_l1d_responder #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  lsu;
    logic [5:0]  rob;
    logic [5:0]  typ;
    logic [63:0] d;
    logic [6:0]  rd;
    logic        e;
  } exp_t;

  typedef struct {
    logic [5:0]  t;
    logic [55:0] a;
    logic [63:0] st;
    logic        c;
    logic [63:0] d;
    logic        e;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          pop_cyc [$];
  exp_t        q [$];
  vec_t        tv [$];
  byte unsigned mref [DEPTH*8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int sz_of(input logic [5:0] t);
    case (t)
      6'd1, 6'd2, 6'd8:  return 1;
      6'd3, 6'd4, 6'd9:  return 2;
      6'd5, 6'd6, 6'd10: return 4;
      default:           return 8;
    endcase
  endfunction

  function automatic void model(input logic [5:0] t,
                                input logic [55:0] a,
                                input logic [63:0] st,
                                input logic c,
                                output logic [63:0] d,
                                output logic e);
    int sz;
    longint unsigned v;
    sz = sz_of(t);
    e = (t < 1) || (t > 11) || (a % sz != 0) ||
        (a >= DEPTH*8) || !c;
    d = '0;
    if (!e) begin
      if (t >= 8) begin
        for (int i = 0; i < sz; i++) mref[a+i] = st[8*i +: 8];
      end else begin
        v = 0;
        for (int i = sz - 1; i >= 0; i--)
          v = (v << 8) | longint'(mref[a+i]);
        if ((t == 1 || t == 3 || t == 5) && v[8*sz-1])
          v = v | ~((64'd1 << (8*sz)) - 64'd1);
        d = v;
      end
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] d;
    logic        er;
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        model(bus.req_type, bus.req_paddr, bus.req_st_dat,
              bus.req_is_cacheable, d, er);
        e.lsu = bus.req_lsu_id;
        e.rob = bus.req_rob_id;
        e.typ = bus.req_type;
        e.d   = d;
        e.rd  = bus.req_ld_rd_idx;
        e.e   = er;
        q.push_back(e);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        pops++;
        pop_cyc.push_back(cyc);
        if (q.size() == 0) begin
          chk("resp_without_req", {63'b0, bus.resp_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          chk("sb_lsu_id", bus.resp_lsu_id, e.lsu);
          chk("sb_rob_id", bus.resp_rob_id, e.rob);
          chk("sb_type", bus.resp_req_type, e.typ);
          chk("sb_ld_data", bus.resp_ld_data, e.d);
          chk("sb_rd_idx", bus.resp_ld_rd_idx, e.rd);
          chk("sb_err", bus.resp_err, e.e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [5:0] t, input logic [55:0] a,
                         input logic [63:0] st, input logic c,
                         input logic [3:0] l, input logic [5:0] r,
                         input logic [6:0] rd);
    bus.req_type         = t;
    bus.req_paddr        = a;
    bus.req_st_dat       = st;
    bus.req_is_cacheable = c;
    bus.req_lsu_id       = l;
    bus.req_rob_id       = r;
    bus.req_ld_rd_idx    = rd;
  endtask

  task automatic send(input logic [5:0] t, input logic [55:0] a,
                      input logic [63:0] st, input logic c,
                      input logic [3:0] l, input logic [5:0] r,
                      input logic [6:0] rd);
    int n;
    n = 0;
    set_req(t, a, st, c, l, r, rd);
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("req_ready_timeout", bus.req_ready, 64'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    while ((q.size() != 0 || bus.resp_valid) && n < 60) begin
      step();
      n++;
    end
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  task automatic add(input logic [5:0] t, input logic [55:0] a,
                     input logic [63:0] st, input logic c,
                     input logic [63:0] d, input logic e);
    vec_t v;
    v.t = t; v.a = a; v.st = st; v.c = c; v.d = d; v.e = e;
    tv.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, accs, p0;
    bus.req_valid     = 1'b0;
    bus.req_is_secure = 1'b0;
    bus.resp_ready    = 1'b0;
    set_req(6'd0, 56'd0, 64'd0, 1'b0, 4'd0, 6'd0, 7'd0);

    add(6'd11, 56'h40, 64'h1122334455667788, 1, 64'h0, 0);
    add(6'd7,  56'h40, 64'h0, 1, 64'h1122334455667788, 0);
    add(6'd8,  56'h13, 64'hFFFFFFFFFFFFFF80, 1, 64'h0, 0);
    add(6'd1,  56'h13, 64'h0, 1, 64'hFFFFFFFFFFFFFF80, 0);
    add(6'd2,  56'h13, 64'h0, 1, 64'h80, 0);
    add(6'd3,  56'h12, 64'h0, 1, 64'hFFFFFFFFFFFF8000, 0);
    add(6'd5,  56'h42, 64'h0, 1, 64'h0, 1);
    add(6'd11, 56'h200, 64'hFFFFFFFFFFFFFFFF, 1, 64'h0, 1);
    add(6'd7,  56'h0,  64'h0, 1, 64'h0, 0);
    add(6'd16, 56'h40, 64'h0, 1, 64'h0, 1);
    add(6'd7,  56'h40, 64'h0, 0, 64'h0, 1);
    add(6'd6,  56'h44, 64'h0, 1, 64'h11223344, 0);
    add(6'd5,  56'h40, 64'h0, 1, 64'h55667788, 0);
    add(6'd9,  56'h40, 64'h1234BEEF, 1, 64'h0, 0);
    add(6'd3,  56'h40, 64'h0, 1, 64'hFFFFFFFFFFFFBEEF, 0);
    add(6'd5,  56'h40, 64'h0, 1, 64'h5566BEEF, 0);
    add(6'd0,  56'h40, 64'h0, 1, 64'h0, 1);
    add(6'd10, 56'h1C, 64'hA5A5A5A587654321, 1, 64'h0, 0);
    add(6'd7,  56'h18, 64'h0, 1, 64'h8765432100000000, 0);
    add(6'd5,  56'h1C, 64'h0, 1, 64'hFFFFFFFF87654321, 0);
    add(6'd4,  56'h43, 64'h0, 1, 64'h0, 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", bus.req_ready, 64'd1);
    chk("rst_resp_valid", bus.resp_valid, 64'd0);
    chk("rst_ld_data", bus.resp_ld_data, 64'd0);
    chk("rst_err", bus.resp_err, 64'd0);

    // Vector table: one request at a time, exact latency each.
    bus.resp_ready = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].t, tv[i].a, tv[i].st, tv[i].c,
           4'(i), 6'(i), 7'(i + 3));
      n = 0;
      while (!bus.resp_valid && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("v%0d_latency", i), 64'(n), 64'(LATENCY - 1));
      chk($sformatf("v%0d_ld_data", i), bus.resp_ld_data, tv[i].d);
      chk($sformatf("v%0d_err", i), bus.resp_err, 64'(tv[i].e));
      chk($sformatf("v%0d_rob", i), bus.resp_rob_id, 64'(i));
      step();
    end
    drain("table_drain");

    // Backpressure: only FIFO_DEPTH accepts with resp_ready low.
    bus.resp_ready = 1'b0;
    accs = 0;
    set_req(6'd7, 56'h40, 64'd0, 1'b1, 4'd1, 6'd40, 7'd9);
    bus.req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.req_ready) accs++;
      step();
      bus.req_rob_id = 6'(40 + accs);
    end
    chk("bp_accepts", 64'(accs), 64'(FIFO_DEPTH));
    chk("bp_req_ready_low", bus.req_ready, 64'd0);
    bus.req_valid  = 1'b0;
    p0 = pops;
    bus.resp_ready = 1'b1;
    chk("bp_ready_before_deq", bus.req_ready, 64'd0);
    step();
    chk("bp_ready_after_deq", bus.req_ready, 64'd1);
    drain("bp_drain");
    chk("bp_resp_count", 64'(pops - p0), 64'(FIFO_DEPTH));

    // Full throughput: 20 back-to-back loads.
    pop_cyc.delete();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_req(6'd7, 56'($urandom_range(0, DEPTH - 1) * 8), 64'd0,
              1'b1, 4'(k), 6'(k), 7'(k));
      chk($sformatf("tp_ready_%0d", k), bus.req_ready, 64'd1);
      step();
    end
    drain("tp_drain");
    chk("tp_resp_count", 64'(pop_cyc.size()), 64'd20);
    if (pop_cyc.size() == 20)
      chk("tp_consecutive", 64'(pop_cyc[19] - pop_cyc[0]), 64'd19);

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic [5:0]  t;
      logic [55:0] a;
      t = ($urandom % 8 != 0) ? 6'($urandom_range(1, 11))
                              : 6'($urandom_range(0, 43));
      a = 56'($urandom_range(0, DEPTH * 8 + 31));
      if ($urandom % 5 != 0) a = a & ~56'(sz_of(t) - 1);
      set_req(t, a, {$urandom, $urandom}, ($urandom % 10 != 0),
              4'($urandom), 6'($urandom), 7'($urandom));
      bus.req_is_secure = 1'($urandom);
      bus.req_valid     = ($urandom % 4 != 0);
      bus.resp_ready    = ($urandom % 3 != 0);
      step();
    end
    drain("rand_drain");

    // Async reset with requests in flight.
    send(6'd11, 56'h40, 64'hDEADBEEFCAFEF00D, 1'b1, 4'd2, 6'd2, 7'd2);
    drain("pre_rst_drain");
    bus.resp_ready = 1'b0;
    set_req(6'd7, 56'h40, 64'd0, 1'b1, 4'd3, 6'd3, 7'd3);
    bus.req_valid = 1'b1;
    repeat (3) step();
    bus.req_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_resp_valid", bus.resp_valid, 64'd0);
    q.delete();
    for (int i = 0; i < DEPTH * 8; i++) mref[i] = 8'd0;
    step();
    rst = 1'b0;
    chk("post_rst_req_ready", bus.req_ready, 64'd1);
    chk("post_rst_resp_valid", bus.resp_valid, 64'd0);
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("post_rst_idle_%0d", k), bus.resp_valid, 64'd0);
    end
    send(6'd7, 56'h40, 64'd0, 1'b1, 4'd5, 6'd5, 7'd5);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      step();
      n++;
    end
    chk("post_rst_latency", 64'(n), 64'(LATENCY - 1));
    chk("post_rst_ld_data", bus.resp_ld_data, 64'd0);
    chk("post_rst_err", bus.resp_err, 64'd0);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ruby_l1d_responder.md
# ruby_l1d_responder

Behavioural L1D responder that terminates the LSU→L1D request channel. It returns one LSU response per accepted request, in order, after a fixed latency, backed by a small internal data array. It sits in the Ruby integration path at the L1D end of the LSU interface. It lets LSU/ROB logic run closed-loop, and lets the Ruby bridge be swapped in later without changing the LSU-facing ports.

## Interface
- LSU_ID_W, default 4: width of lsu_id.
- ROB_TAG_W, default 6: width of rob_id.
- PREG_TAG_W, default 7: width of ld_rd_idx.
- PADDR_W, default 56: physical address width.
- DEPTH, default 64: 64-bit words in the data array; power of two, ≥2.
- LATENCY, default 3: accept-to-earliest-response cycles; ≥1.
- FIFO_DEPTH, default 4: maximum outstanding requests; power of two, ≥2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  responder can accept.
- req_lsu_id  in  LSU_ID_W  LSU tag.
- req_rob_id  in  ROB_TAG_W  ROB tag.
- req_type  in  6  lsu_op_e code: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWU=6, LD=7, SB=8, SH=9, SW=10, SD=11; 12–43 are other ops.
- req_paddr  in  PADDR_W  byte address.
- req_ld_rd_idx  in  PREG_TAG_W  destination preg.
- req_st_dat  in  64  store data, right-aligned.
- req_is_cacheable  in  1  cacheable attribute.
- req_is_secure  in  1  secure attribute (ignored).
- resp_valid  out  1  response valid.
- resp_ready  in  1  LSU accepts response.
- resp_lsu_id  out  LSU_ID_W  echoed.
- resp_rob_id  out  ROB_TAG_W  echoed.
- resp_req_type  out  6  echoed.
- resp_ld_data  out  64  load result, extended.
- resp_ld_rd_idx  out  PREG_TAG_W  echoed.
- resp_err  out  1  request failed.

## Operation
- Request accept: req_valid && req_ready. Response handshake: resp_valid && resp_ready.
- Data-array access happens in the accept cycle.
  - Word index = paddr[3 +: log2(DEPTH)].
  - Byte offset = paddr[2:0].
  - Size: B=1, H=2, W=4, D=8 bytes.
- Loads: extract the bytes at the offset. LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU/LD zero-extend.
- Stores: write the low size bytes of st_dat at the offset using byte enables. ld_data=0 in the response.
- err=1, with no array write and ld_data=0, when any of these holds:
  - req_type is outside 1–11;
  - paddr is misaligned for the access size;
  - paddr ≥ DEPTH*8;
  - req_is_cacheable=0.
- Every accepted request yields exactly one response, including erroring ones. Responses are strictly in accept order.
- Internal structure:
  - Accept-time result enters a LATENCY-stage valid/payload shift pipeline.
  - Stage LATENCY output pushes into an output FIFO of FIFO_DEPTH entries.
  - The FIFO head drives resp_*.
- Credit counter inflight = requests accepted but not yet handshaken on resp.
  - Width log2(FIFO_DEPTH)+1.
  - req_ready = (inflight < FIFO_DEPTH).
  - Accept and response in the same cycle leave inflight unchanged.
  - The FIFO can never overflow.
- The pipeline never stalls. Backpressure appears only through req_ready.

## Timing
- Reset values:
  - req_ready=1 as soon as rst deasserts.
  - resp_valid=0.
  - All resp_* payload=0.
  - inflight=0; pipeline valids and FIFO pointers cleared.
  - Data array zeroed.
- Reset mid-operation discards all in-flight requests and stored data asynchronously. No response is produced for them.
- Load-to-response: a request accepted at cycle T gives resp_valid=1 at T+LATENCY if the FIFO is empty ahead of it.
- One accept per cycle maximum. One response per cycle maximum. Sustained throughput is 1/cycle when FIFO_DEPTH ≥ LATENCY+1.
- Store at T followed by load to the same word at T+1 returns the stored data (array written at the T edge).
- req_ready depends only on registered state, not combinationally on resp_ready.
- resp_* holds stable while resp_valid && !resp_ready.
- FIFO full and pipeline-push in the same cycle cannot occur, because credits guarantee space.
- FIFO/pointer wrap uses modulo-FIFO_DEPTH pointers with an extra wrap bit.

## Test plan
- Store/load roundtrip: SD 0x1122334455667788 @0x40, then LD @0x40 → two responses in order. The LD gives ld_data=0x1122334455667788, err=0, echoed lsu_id/rob_id/rd_idx. The first response arrives exactly LATENCY cycles after accept.
- Sign/zero extension: SB 0x80 @0x13, then LB @0x13 → 0xFFFFFFFFFFFFFF80. LBU → 0x80. LH @0x12 → 0xFFFFFFFFFFFF8000.
- Errors:
  - LW @0x42 (misaligned) → err=1, ld_data=0.
  - SD @DEPTH*8 → err=1, and a subsequent LD @0 is unchanged.
  - req_type=16 (AMOSWAPW) → err=1.
  - is_cacheable=0 LD → err=1.
- Backpressure: hold resp_ready=0 and drive req_valid continuously. Exactly FIFO_DEPTH accepts occur, then req_ready=0. Releasing resp_ready drains all FIFO_DEPTH responses in order, with req_ready=1 the cycle after the first dequeue.
- Full throughput: resp_ready=1 and 20 back-to-back LDs with rob_id 0..19 → 20 responses on consecutive cycles with rob_id 0..19 in order.
- Async reset: assert rst with 3 requests in flight → resp_valid=0 and req_ready=1 immediately after release, no stale responses, and LD @0x40 returns 0.
